// File: rtl/iommu_dc_fetch_if.sv
// Burst read port used to fetch device-context entries from memory.
// The master issues one request, then drains the beats returned on the read channel.
interface iommu_dc_fetch_if #(
    parameter int AddrW = 56
);
    logic             mem_req;
    logic             mem_gnt;
    logic [AddrW-1:0] mem_addr;
    logic [7:0]       mem_len;
    logic             mem_rvalid;
    logic [63:0]      mem_rdata;
    logic             mem_rerr;
    logic             mem_rlast;

    modport master (
        output mem_req, mem_addr, mem_len,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_rerr, mem_rlast
    );

    modport slave (
        input  mem_req, mem_addr, mem_len,
        output mem_gnt, mem_rvalid, mem_rdata, mem_rerr, mem_rlast
    );
endinterface

// File: rtl/iommu_dc_fetch.sv
// Device-context fetcher: one burst read of a leaf DDT entry, assembly into the
// extended DC layout, field validation, then a done pulse with an optional fault cause.
module iommu_dc_fetch #(
    parameter bit MSITrans = 1'b1,
    parameter int AddrW    = 56
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_i,
    input  logic [AddrW-1:0] dc_addr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [11:0]      cause_o,
    output logic [511:0]     dc_o,
    iommu_dc_fetch_if.master mem
);

    localparam int               NumDw     = MSITrans ? 8 : 4;
    localparam logic [2:0]       LastIdx   = 3'(NumDw - 1);
    localparam logic [AddrW-1:0] AlignMask = AddrW'(MSITrans ? 63 : 31);

    // Doubleword bit offsets inside the assembled DC (doubleword 0 at lowest address)
    localparam int TcOff  = 0;
    localparam int IohOff = 64;
    localparam int TaOff  = 128;
    localparam int FscOff = 192;
    localparam int MsiOff = 256;
    localparam int MskOff = 320;
    localparam int PatOff = 384;
    localparam int RsvOff = 448;

    localparam logic [11:0] CauseLoadFault = 12'd257;
    localparam logic [11:0] CauseNotValid  = 12'd258;
    localparam logic [11:0] CauseMisconfig = 12'd259;

    typedef enum logic [1:0] {IDLE, REQ, RECV, CHECK} state_e;

    state_e           state_reg;
    logic [2:0]       cnt_reg;
    logic             err_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;
    logic [11:0]      cause_reg;
    logic [511:0]     dc_reg;
    logic             req_reg;
    logic [AddrW-1:0] addr_reg;
    logic [7:0]       len_reg;
    logic             misconf;

    always_comb begin
        misconf = 1'b0;
        if (dc_reg[TcOff+63:TcOff+12] != '0 || dc_reg[TaOff+11:TaOff] != '0 ||
            dc_reg[TaOff+63:TaOff+32] != '0 || dc_reg[FscOff+59:FscOff+44] != '0)
            misconf = 1'b1;
        if (!(dc_reg[IohOff+63:IohOff+60] inside {4'd0, 4'd8}))
            misconf = 1'b1;
        // pdtv selects whether fsc holds a PDT pointer or a first-stage page table
        if (!dc_reg[TcOff+5] && !(dc_reg[FscOff+63:FscOff+60] inside {4'd0, 4'd8}))
            misconf = 1'b1;
        if (dc_reg[TcOff+5] && dc_reg[FscOff+63:FscOff+60] > 4'd3)
            misconf = 1'b1;
        if (MSITrans) begin
            if (dc_reg[MsiOff+59:MsiOff+44] != '0 || dc_reg[MsiOff+63:MsiOff+60] > 4'd1 ||
                dc_reg[MskOff+63:MskOff+52] != '0 || dc_reg[PatOff+63:PatOff+52] != '0 ||
                dc_reg[RsvOff+63:RsvOff] != '0)
                misconf = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            cause_reg <= '0;
            dc_reg    <= '0;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
            len_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (init_i) begin
                        addr_reg  <= dc_addr_i & ~AlignMask;
                        len_reg   <= 8'(NumDw - 1);
                        dc_reg    <= '0;
                        err_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        error_reg <= 1'b0;
                        cause_reg <= '0;
                        req_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        req_reg   <= 1'b0;
                        state_reg <= RECV;
                    end
                end
                RECV: begin
                    if (mem.mem_rvalid) begin
                        dc_reg[{cnt_reg, 6'd0} +: 64] <= mem.mem_rdata;
                        cnt_reg <= cnt_reg + 3'd1;
                        if (mem.mem_rerr)
                            err_reg <= 1'b1;
                        // A short burst leaves the remaining doublewords at zero
                        if (mem.mem_rlast || cnt_reg == LastIdx)
                            state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                    if (err_reg) begin
                        error_reg <= 1'b1;
                        cause_reg <= CauseLoadFault;
                    end else if (!dc_reg[TcOff]) begin
                        error_reg <= 1'b1;
                        cause_reg <= CauseNotValid;
                    end else if (misconf) begin
                        error_reg <= 1'b1;
                        cause_reg <= CauseMisconfig;
                    end else begin
                        error_reg <= 1'b0;
                        cause_reg <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy_reg;
    assign done_o       = done_reg;
    assign error_o      = error_reg;
    assign cause_o      = cause_reg;
    assign dc_o         = dc_reg;
    assign mem.mem_req  = req_reg;
    assign mem.mem_addr = addr_reg;
    assign mem.mem_len  = len_reg;

endmodule

// File: tb/tb_iommu_dc_fetch.sv
// Bench for the DC fetcher: table of DC images run through an extended-format instance
// with a scoreboard, plus hand sequences for base format and mid-burst reset.
module tb_iommu_dc_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         init, init_b;
    logic [55:0]  addr, addr_b;
    logic         busy, done, error, busy_b, done_b, error_b;
    logic [11:0]  cause, cause_b;
    logic [511:0] dc, dc_b;

    iommu_dc_fetch_if #(.AddrW(56)) mif ();
    iommu_dc_fetch_if #(.AddrW(56)) mif_b ();

    iommu_dc_fetch #(.MSITrans(1'b1), .AddrW(56)) u_ext (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .dc_addr_i(addr),
        .busy_o(busy), .done_o(done), .error_o(error), .cause_o(cause), .dc_o(dc),
        .mem(mif)
    );

    iommu_dc_fetch #(.MSITrans(1'b0), .AddrW(56)) u_base (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init_b), .dc_addr_i(addr_b),
        .busy_o(busy_b), .done_o(done_b), .error_o(error_b), .cause_o(cause_b), .dc_o(dc_b),
        .mem(mif_b)
    );

    typedef struct {
        string            name;
        logic [7:0][63:0] dw;
        int               err_beat;
        int               n;
        int               gnt_dly;
        int               gap;
        bit               e;
        logic [11:0]      c;
    } vec_t;

    typedef struct {
        bit           e;
        logic [11:0]  c;
        logic [511:0] dc;
        int           lat;
    } exp_t;

    vec_t   tbl[$];
    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    longint cyc = 0;

    localparam logic [63:0] IOH = 64'h8000_0000_0001_2345;
    localparam logic [55:0] TXN_ADDR = 56'h12_3456_789A_BC3F;
    localparam logic [55:0] TXN_ADDR_AL = 56'h12_3456_789A_BC00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [63:0] tc, io, ta, fsc, msip, msk,
                                pat, rs, input int eb, n, gd, gp, input bit e, input logic [11:0] c);
        vec_t v;
        v.name = nm;
        v.dw[0] = tc;   v.dw[1] = io;  v.dw[2] = ta;  v.dw[3] = fsc;
        v.dw[4] = msip; v.dw[5] = msk; v.dw[6] = pat; v.dw[7] = rs;
        v.err_beat = eb; v.n = n; v.gnt_dly = gd; v.gap = gp; v.e = e; v.c = c;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        exp_t         x;
        logic [511:0] edc;
        longint       t0;
        int           w;
        edc = '0;
        for (int b = 0; b < v.n; b++) edc[b*64 +: 64] = v.dw[b];
        x.e = v.e; x.c = v.c; x.dc = edc;
        x.lat = (v.gnt_dly == 0 && v.gap == 0) ? v.n + 3 : -1;
        exp_q.push_back(x);

        addr = TXN_ADDR;
        init = 1'b1;
        t0 = cyc;
        tick();
        init = 1'b0;
        w = 0;
        while (mif.mem_req !== 1'b1 && w < 20) begin tick(); w++; end
        chk({v.name, " req"}, 512'(mif.mem_req), 512'(1));
        for (int d = 0; d < v.gnt_dly; d++) begin
            chk({v.name, " req_hold"}, 512'(mif.mem_req), 512'(1));
            chk({v.name, " addr_hold"}, 512'(mif.mem_addr), 512'(TXN_ADDR_AL));
            chk({v.name, " len_hold"}, 512'(mif.mem_len), 512'(7));
            tick();
        end
        chk({v.name, " addr"}, 512'(mif.mem_addr), 512'(TXN_ADDR_AL));
        chk({v.name, " len"}, 512'(mif.mem_len), 512'(7));
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt = 1'b0;
        chk({v.name, " req_drop"}, 512'(mif.mem_req), 512'(0));

        for (int b = 0; b < v.n; b++) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = v.dw[b];
            mif.mem_rerr   = (b == v.err_beat);
            mif.mem_rlast  = (b == v.n - 1);
            tick();
            mif.mem_rvalid = 1'b0;
            mif.mem_rerr   = 1'b0;
            mif.mem_rlast  = 1'b0;
            chk({v.name, " no_early_done"}, 512'(done), 512'(0));
            for (int g = 0; g < v.gap && b != v.n - 1; g++) begin
                if (b == 0 && g == 0) begin
                    // a second start while busy must be ignored
                    chk({v.name, " busy"}, 512'(busy), 512'(1));
                    init = 1'b1;
                    addr = 56'h00_0000_0000_0040;
                end
                tick();
                init = 1'b0;
            end
        end

        w = 0;
        while (done !== 1'b1 && w < 40) begin tick(); w++; end
        x = exp_q.pop_front();
        if (done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s done_timeout: got no done_o, expected done_o", v.name);
            return;
        end
        chk({v.name, " error"}, 512'(error), 512'(x.e));
        chk({v.name, " cause"}, 512'(cause), 512'(x.c));
        chk({v.name, " dc"}, dc, x.dc);
        if (x.lat >= 0) chk({v.name, " latency"}, 512'(cyc - t0), 512'(x.lat));
        $display("txn %s: error=%0d cause=%0d latency=%0d", v.name, error, cause, cyc - t0);
        tick();
        chk({v.name, " done_pulse"}, 512'(done), 512'(0));
        chk({v.name, " idle"}, 512'(busy), 512'(0));
    endtask

    initial begin
        longint t0;
        int     w;
        logic [3:0][63:0] bdw;

        rst_n = 1'b0; init = 1'b0; init_b = 1'b0; addr = '0; addr_b = '0;
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
        mif.mem_rerr = 1'b0; mif.mem_rlast = 1'b0;
        mif_b.mem_gnt = 1'b0; mif_b.mem_rvalid = 1'b0; mif_b.mem_rdata = '0;
        mif_b.mem_rerr = 1'b0; mif_b.mem_rlast = 1'b0;

        tbl.push_back(mk("valid",          64'h1, IOH, 0, 0, 0, 0, 0, 0, -1, 8, 0, 0, 0, 12'd0));
        tbl.push_back(mk("rerr_beat2",     64'h1, IOH, 0, 0, 0, 0, 0, 0,  2, 8, 0, 0, 1, 12'd257));
        tbl.push_back(mk("v_clear",        64'h0, IOH, 0, 0, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd258));
        tbl.push_back(mk("tc_rsvd12",   64'h1001, IOH, 0, 0, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("fsc_mode9",      64'h1, IOH, 0, 64'h9000_0000_0000_0000, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("pdtv_mode3",    64'h21, IOH, 0, 64'h3000_0000_0000_1000, 0, 0, 0, 0, -1, 8, 0, 0, 0, 12'd0));
        tbl.push_back(mk("pdtv_mode4",    64'h21, IOH, 0, 64'h4000_0000_0000_0000, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("iohgatp_mode9",  64'h1, 64'h9000_0000_0000_0001, 0, 0, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("msiptp_mode2",   64'h1, IOH, 0, 0, 64'h2000_0000_0000_0000, 0, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("rsvd_dw7",       64'h1, IOH, 0, 0, 0, 0, 0, 64'h1, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("ta_rsvd1",       64'h1, IOH, 64'h1, 0, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("ta_rsvd2",       64'h1, IOH, 64'h1_0000_0000, 0, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("mask_rsvd",      64'h1, IOH, 0, 0, 0, 64'h0010_0000_0000_0000, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("fsc_rsvd",       64'h1, IOH, 0, 64'h0000_1000_0000_0000, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd259));
        tbl.push_back(mk("err_last_vclr",  64'h0, IOH, 0, 0, 0, 0, 0, 0,  7, 8, 0, 0, 1, 12'd257));
        tbl.push_back(mk("vclr_over_misc", 64'h1000, IOH, 0, 0, 0, 0, 0, 0, -1, 8, 0, 0, 1, 12'd258));
        tbl.push_back(mk("stall_gaps",     64'h3, 64'h8ABC_0000_0001_2345, 64'h0000_0000_1234_5000,
                         64'h8000_0000_0000_0ABC, 64'h1000_0000_0000_0055, 64'h000F_FFFF_FFFF_FFFF,
                         64'h000A_BCDE_F012_3456, 0, -1, 8, 5, 2, 0, 12'd0));
        tbl.push_back(mk("early_rlast",    64'h1, IOH, 0, 0, 0, 0, 0, 0, -1, 4, 0, 0, 0, 12'd0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 512'(busy), 512'(0));
        chk("reset done", 512'(done), 512'(0));
        chk("reset cause", 512'(cause), 512'(0));
        chk("reset dc", dc, 512'(0));
        chk("reset req", 512'(mif.mem_req), 512'(0));
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) run_txn(tbl[i]);

        // Base format: 4 doublewords, 32-byte alignment
        bdw[0] = 64'h1; bdw[1] = IOH; bdw[2] = 64'h0000_0000_0ABC_D000; bdw[3] = 64'h8000_0000_0000_0123;
        addr_b = 56'h00_0000_8000_101F;
        init_b = 1'b1;
        t0 = cyc;
        tick();
        init_b = 1'b0;
        chk("base req", 512'(mif_b.mem_req), 512'(1));
        chk("base addr", 512'(mif_b.mem_addr), 512'(56'h00_0000_8000_1000));
        chk("base len", 512'(mif_b.mem_len), 512'(3));
        mif_b.mem_gnt = 1'b1;
        tick();
        mif_b.mem_gnt = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mif_b.mem_rvalid = 1'b1;
            mif_b.mem_rdata  = bdw[b];
            mif_b.mem_rlast  = (b == 3);
            tick();
        end
        mif_b.mem_rvalid = 1'b0;
        mif_b.mem_rlast  = 1'b0;
        w = 0;
        while (done_b !== 1'b1 && w < 20) begin tick(); w++; end
        chk("base done", 512'(done_b), 512'(1));
        chk("base latency", 512'(cyc - t0), 512'(7));
        chk("base error", 512'(error_b), 512'(0));
        chk("base dc_low", 512'(dc_b[255:0]), 512'(bdw));
        chk("base dc_high", 512'(dc_b[511:256]), 512'(0));
        $display("txn base: error=%0d cause=%0d latency=%0d", error_b, cause_b, cyc - t0);

        // Reset after three beats, then stray beats while idle
        addr = TXN_ADDR;
        init = 1'b1;
        tick();
        init = 1'b0;
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = 64'hA5A5_0000_0000_0000 | 64'(b + 1);
            tick();
        end
        mif.mem_rvalid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst busy", 512'(busy), 512'(0));
        chk("rst done", 512'(done), 512'(0));
        chk("rst error", 512'(error), 512'(0));
        chk("rst cause", 512'(cause), 512'(0));
        chk("rst dc", dc, 512'(0));
        chk("rst req", 512'(mif.mem_req), 512'(0));
        chk("rst addr", 512'(mif.mem_addr), 512'(0));
        tick();
        rst_n = 1'b1;
        for (int b = 0; b < 3; b++) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = '1;
            mif.mem_rlast  = (b == 2);
            tick();
        end
        mif.mem_rvalid = 1'b0;
        mif.mem_rlast  = 1'b0;
        chk("stray dc", dc, 512'(0));
        chk("stray busy", 512'(busy), 512'(0));
        chk("stray done", 512'(done), 512'(0));
        $display("txn reset_mid_burst: dc=%0h busy=%0d", dc, busy);
        run_txn(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
